dbus_bridge: RTL and testbench
==============================

DBUS_BRIDGE -- requirements
Module: dbus_bridge

Interface
REQ-001 Parameter list (name, default, meaning); the block SHALL provide exactly these:
- ADDR_MAP, default 1: 1 = apply fixed kseg0/kseg1 translation; 0 = pass addresses through unchanged.
- RESET_RD, default 32'h0: value of rd after reset.

REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be exactly these (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mread_valid  in  1  memory stage requests a load.
- mread_addr  in  32  load virtual address.
- mread_size  in  2  load size: 00 byte, 01 half, 10 word.
- mwrite_valid  in  1  memory stage requests a store.
- mwrite_addr  in  32  store virtual address.
- mwrite_data  in  32  store data, already lane-aligned.
- mwrite_size  in  2  store size, same encoding as mread_size.
- advance  in  1  M->W pipeline register updates this cycle.
- rd  out  32  raw load data returned to the memory stage.
- busy  out  1  stall request to the hazard unit.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  bus transfer size.
- data_addr  out  32  physical address.
- data_wdata  out  32  bus write data.
- data_addr_ok  in  1  slave accepted the address phase.
- data_data_ok  in  1  slave completed the data phase.
- data_rdata  in  32  bus read data.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, ADDR, DATA, HOLD.

REQ-005 IDLE with (mread_valid | mwrite_valid): latch the request (wr, size, translated addr, wdata) into registers and go to ADDR next cycle.

REQ-006 mread_valid and mwrite_valid both high: the store SHALL win (illegal input, deterministic handling).

REQ-007 In ADDR, data_req SHALL be 1 and data_wr, data_size, data_addr and data_wdata SHALL be driven from the latched registers only; these outputs SHALL be stable until data_addr_ok.

REQ-008 ADDR with data_addr_ok=1 and data_data_ok=0: go to DATA, and data_req SHALL drop the next cycle.

REQ-009 ADDR with data_addr_ok=1 and data_data_ok=1 in the same cycle: go directly to HOLD.

REQ-010 DATA with data_data_ok=1: go to HOLD; for a read, capture data_rdata into the rd register.

REQ-011 A write SHALL leave the rd register unchanged.

REQ-012 HOLD: rd SHALL present the captured value; the FSM stays in HOLD until advance=1, then goes to IDLE.

REQ-013 busy SHALL be 1 in ADDR and DATA, and 1 in IDLE when (mread_valid | mwrite_valid); it SHALL be 0 in HOLD and 0 in IDLE with no request.

REQ-014 One request per memory-stage instruction: HOLD blocks reissue until advance, and at most one bus transaction SHALL be outstanding.

REQ-015 HOLD with advance=1 and a new request valid SHALL pass through IDLE, which launches it on the following cycle (one-cycle gap, busy=1 in IDLE).

REQ-016 data_data_ok received in IDLE or HOLD SHALL be ignored.

REQ-017 data_addr_ok outside ADDR SHALL be ignored.

REQ-018 Address translation with ADDR_MAP=1:
- 0x8000_0000..0xBFFF_FFFF -> addr & 32'h1FFF_FFFF.
- All other addresses pass unchanged.

REQ-019 Address translation with ADDR_MAP=0: all addresses pass unchanged.

REQ-020 Alignment SHALL NOT be checked; misaligned accesses are forwarded as issued.

REQ-021 Outside ADDR, data_req=0 and the other bus outputs hold their last latched values.

Reset
REQ-022 Reset SHALL force:
- FSM to IDLE.
- data_req=0, data_wr=0, data_size=2'b00, data_addr=0, data_wdata=0.
- rd=RESET_RD.
- busy reflecting only the IDLE rule (REQ-013).

REQ-023 Reset asserted in ADDR or DATA SHALL abandon the transaction with no rd update; the bus slave shares this reset.

Verification
REQ-024 Word load at vaddr 0x8000_1000, addr_ok on cycle 2, data_ok=0xDEADBEEF on cycle 4 -> data_addr=0x0000_1000, data_size=10, data_wr=0, busy=1 until HOLD, rd=0xDEADBEEF, busy=0 in HOLD.

REQ-025 Byte store at vaddr 0xA000_0003, data 0x7700_0000, slave asserts addr_ok and data_ok in the same cycle -> data_addr=0x0000_0003, data_wr=1, ADDR->HOLD directly, rd unchanged.

REQ-026 Load completes while advance=0 for 3 cycles -> FSM stays in HOLD, exactly one data_req transaction, busy=0, rd stable; advance=1 -> IDLE.

REQ-027 Back-to-back: store in HOLD with advance=1 and a new load valid -> IDLE for one cycle with busy=1, then ADDR with data_wr=0.

REQ-028 Reset in DATA, followed by a stray data_ok=0x12345678 -> IDLE, rd=RESET_RD, data_req=0, stray data_ok ignored.

REQ-029 ADDR_MAP=0, load at 0xBFC0_0000 -> data_addr=0xBFC0_0000.

Source files
------------

// File: rtl/dbus_bridge.sv
// dbus_bridge: memory-stage to data-bus bridge with one outstanding transaction and a HOLD state until the pipeline advances.
module dbus_bridge #(
   parameter bit          ADDR_MAP = 1'b1,
   parameter logic [31:0] RESET_RD = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mread_valid,
   input  logic [31:0] mread_addr,
   input  logic [1:0]  mread_size,
   input  logic        mwrite_valid,
   input  logic [31:0] mwrite_addr,
   input  logic [31:0] mwrite_data,
   input  logic [1:0]  mwrite_size,
   input  logic        advance,
   output logic [31:0] rd,
   output logic        busy,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
   state_t state;
   logic        req_valid;
   logic [31:0] raw_addr;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   // a store wins when both requests are raised
   always_comb begin
      req_valid = mread_valid || mwrite_valid;
      raw_addr  = mwrite_valid ? mwrite_addr : mread_addr;
      req_size  = mwrite_valid ? mwrite_size : mread_size;
      req_addr  = (ADDR_MAP && raw_addr[31:30] == 2'b10) ? (raw_addr & 32'h1fff_ffff) : raw_addr;
   end
   assign data_req = state == ADDR;
   assign busy     = state == ADDR || state == DATA || (state == IDLE && req_valid);
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         data_wr    <= 1'b0;
         data_size  <= 2'b00;
         data_addr  <= 32'h0;
         data_wdata <= 32'h0;
         rd         <= RESET_RD;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               state      <= ADDR;
               data_wr    <= mwrite_valid;
               data_size  <= req_size;
               data_addr  <= req_addr;
               data_wdata <= mwrite_data;
            end
            ADDR: if (data_addr_ok) begin
               state <= data_data_ok ? HOLD : DATA;
               if (data_data_ok && !data_wr) rd <= data_rdata;
            end
            DATA: if (data_data_ok) begin
               state <= HOLD;
               if (!data_wr) rd <= data_rdata;
            end
            HOLD: if (advance) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: directed scoreboard bench for dbus_bridge, with a second instance built with address translation off.
module tb_dbus_bridge;
   localparam logic [31:0] RRD = 32'hcafe_f00d;
   logic        clk = 1'b0, reset = 1'b1;
   logic        mread_valid = 1'b0, mwrite_valid = 1'b0, advance = 1'b0;
   logic [31:0] mread_addr = '0, mwrite_addr = '0, mwrite_data = '0;
   logic [1:0]  mread_size = '0, mwrite_size = '0;
   logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;
   logic [31:0] rd, data_addr, data_wdata, rd1, addr1, wdata1;
   logic        busy, data_req, data_wr, busy1, req1, wr1;
   logic [1:0]  data_size, size1;
   int          total = 0, fails = 0, n_acc = 0, acc0;
   logic [31:0] sb[$];
   logic [31:0] model_rd;
   always #5 clk = ~clk;
   dbus_bridge #(.ADDR_MAP(1'b1), .RESET_RD(RRD)) u0 (
      .clk(clk), .reset(reset), .mread_valid(mread_valid), .mread_addr(mread_addr), .mread_size(mread_size),
      .mwrite_valid(mwrite_valid), .mwrite_addr(mwrite_addr), .mwrite_data(mwrite_data), .mwrite_size(mwrite_size),
      .advance(advance), .rd(rd), .busy(busy), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata));
   dbus_bridge #(.ADDR_MAP(1'b0), .RESET_RD(RRD)) u1 (
      .clk(clk), .reset(reset), .mread_valid(mread_valid), .mread_addr(mread_addr), .mread_size(mread_size),
      .mwrite_valid(mwrite_valid), .mwrite_addr(mwrite_addr), .mwrite_data(mwrite_data), .mwrite_size(mwrite_size),
      .advance(advance), .rd(rd1), .busy(busy1), .data_req(req1), .data_wr(wr1), .data_size(size1),
      .data_addr(addr1), .data_wdata(wdata1), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata));
   always @(posedge clk) if (!reset && data_req && data_addr_ok) n_acc++;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_rd(input string tag);
      if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      else chk(tag, rd, sb.pop_front());
   endtask
   // full transaction up to HOLD; aw/dw are extra wait cycles before addr_ok / data_ok
   task automatic xact(input string tag, input bit wr, input bit both, input logic [31:0] va, input logic [31:0] pa,
                       input logic [31:0] wd, input logic [1:0] sz, input logic [31:0] rdat, input bit same,
                       input int aw, input int dw);
      mwrite_valid = wr;
      mread_valid  = !wr || both;
      mwrite_addr  = va;
      mwrite_data  = wd;
      mwrite_size  = sz;
      mread_addr   = wr ? 32'h8000_0010 : va;
      mread_size   = wr ? 2'b00 : sz;
      model_rd     = wr ? model_rd : rdat;
      sb.push_back(model_rd);
      #1 chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd1);
      tick;
      for (int i = 0; i <= aw; i++) begin
         chk({tag, "_req"}, {31'd0, data_req}, 32'd1);
         chk({tag, "_wr"}, {31'd0, data_wr}, {31'd0, wr});
         chk({tag, "_size"}, {30'd0, data_size}, {30'd0, sz});
         chk({tag, "_addr"}, data_addr, pa);
         chk({tag, "_addr_nomap"}, addr1, va);
         if (wr) chk({tag, "_wdata"}, data_wdata, wd);
         chk({tag, "_addr_busy"}, {31'd0, busy}, 32'd1);
         data_addr_ok = i == aw;
         data_data_ok = same && i == aw;
         data_rdata   = rdat;
         tick;
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (!same) begin
         for (int i = 0; i <= dw; i++) begin
            chk({tag, "_data_req"}, {31'd0, data_req}, 32'd0);
            chk({tag, "_data_busy"}, {31'd0, busy}, 32'd1);
            data_data_ok = i == dw;
            tick;
         end
         data_data_ok = 1'b0;
      end
      #1 chk({tag, "_hold_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hold_req"}, {31'd0, data_req}, 32'd0);
      chk_rd({tag, "_rd"});
   endtask
   task automatic release_hold(input string tag);
      advance      = 1'b1;
      mread_valid  = 1'b0;
      mwrite_valid = 1'b0;
      tick;
      advance = 1'b0;
      #1 chk({tag, "_rel_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rel_req"}, {31'd0, data_req}, 32'd0);
   endtask
   initial begin
      model_rd = RRD;
      repeat (2) tick;
      reset = 1'b0;
      #1 chk("rst_rd", rd, RRD);
      chk("rst_req", {31'd0, data_req}, 32'd0);
      chk("rst_wr", {31'd0, data_wr}, 32'd0);
      chk("rst_size", {30'd0, data_size}, 32'd0);
      chk("rst_addr", data_addr, 32'd0);
      chk("rst_wdata", data_wdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      // stray handshakes in IDLE must not start anything or touch rd
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'h0000_0099;
      tick;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      chk("idle_stray_req", {31'd0, data_req}, 32'd0);
      chk("idle_stray_rd", rd, RRD);
      acc0 = n_acc;
      xact("ld_word", 1'b0, 1'b0, 32'h8000_1000, 32'h0000_1000, 32'h0, 2'b10, 32'hdead_beef, 1'b0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         data_addr_ok = 1'b1;
         data_data_ok = 1'b1;
         data_rdata   = 32'h0bad_0bad;
         mread_valid  = 1'b1;
         tick;
         chk("hold_busy", {31'd0, busy}, 32'd0);
         chk("hold_req", {31'd0, data_req}, 32'd0);
         chk("hold_rd", rd, 32'hdead_beef);
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      chk("one_xact", n_acc - acc0, 32'd1);
      release_hold("ld_word");
      xact("st_byte", 1'b1, 1'b0, 32'ha000_0003, 32'h0000_0003, 32'h7700_0000, 2'b00, 32'h5555_5555, 1'b1, 0, 0);
      advance      = 1'b1;
      mwrite_valid = 1'b0;
      mread_valid  = 1'b1;
      mread_addr   = 32'h0000_2004;
      mread_size   = 2'b01;
      tick;
      advance = 1'b0;
      #1 chk("b2b_idle_busy", {31'd0, busy}, 32'd1);
      chk("b2b_idle_req", {31'd0, data_req}, 32'd0);
      tick;
      chk("b2b_req", {31'd0, data_req}, 32'd1);
      chk("b2b_wr", {31'd0, data_wr}, 32'd0);
      chk("b2b_addr", data_addr, 32'h0000_2004);
      chk("b2b_size", {30'd0, data_size}, 32'd1);
      data_addr_ok = 1'b1;
      tick;
      data_addr_ok = 1'b0;
      chk("b2b_data_busy", {31'd0, busy}, 32'd1);
      chk("b2b_data_req", {31'd0, data_req}, 32'd0);
      reset       = 1'b1;
      mread_valid = 1'b0;
      tick;
      reset    = 1'b0;
      model_rd = RRD;
      #1 chk("abort_rd", rd, RRD);
      chk("abort_req", {31'd0, data_req}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_addr", data_addr, 32'd0);
      data_data_ok = 1'b1;
      data_rdata   = 32'h1234_5678;
      tick;
      data_data_ok = 1'b0;
      chk("stray_rd", rd, RRD);
      chk("stray_req", {31'd0, data_req}, 32'd0);
      chk("stray_busy", {31'd0, busy}, 32'd0);
      xact("st_wins", 1'b1, 1'b1, 32'hbfff_fffc, 32'h1fff_fffc, 32'h1122_3344, 2'b10, 32'h6666_6666, 1'b0, 0, 0);
      release_hold("st_wins");
      xact("ld_bfc", 1'b0, 1'b0, 32'hbfc0_0000, 32'h1fc0_0000, 32'h0, 2'b10, 32'h0102_0304, 1'b1, 2, 0);
      release_hold("ld_bfc");
      xact("ld_c000", 1'b0, 1'b0, 32'hc000_0000, 32'hc000_0000, 32'h0, 2'b10, 32'ha5a5_0001, 1'b0, 0, 2);
      release_hold("ld_c000");
      xact("ld_7fff", 1'b0, 1'b0, 32'h7fff_fffc, 32'h7fff_fffc, 32'h0, 2'b10, 32'h5a5a_0002, 1'b0, 1, 0);
      release_hold("ld_7fff");
      xact("ld_misal", 1'b0, 1'b0, 32'h8000_0001, 32'h0000_0001, 32'h0, 2'b01, 32'h0000_beef, 1'b1, 0, 0);
      release_hold("ld_misal");
      xact("st_half", 1'b1, 1'b0, 32'h0000_0042, 32'h0000_0042, 32'hab00_0000, 2'b01, 32'hffff_ffff, 1'b0, 0, 1);
      release_hold("st_half");
      chk("final_rd", rd, 32'h0000_beef);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
